// File: rtl/instruction_decoder.sv
// Command-FIFO instruction decoder: pops LINE/RECT/FRECT/ALPHA words and fills a small decoded-shape buffer.
// Optional DECODE_CLIP_EN clamps committed coordinates to the screen; undefined leaves them untouched.
module instruction_decoder #(
    parameter int DATA_W   = 32,
    parameter int COORD_W  = 10,
    parameter int DEPTH    = 2,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          decode_en,
    input  logic [DATA_W-1:0]             fifo_rdata,
    input  logic                          fifo_empty,
    output logic                          fifo_pop,
    input  logic                          draw_fin,
    input  logic                          alpha_fin,
    output logic                          decode_fin,
    output logic                          inst_type,
    output logic                          decode_full,
    output logic                          draw_valid,
    output logic [1:0]                    draw_op,
    output logic [COORD_W-1:0]            draw_x0,
    output logic [COORD_W-1:0]            draw_y0,
    output logic [COORD_W-1:0]            draw_x1,
    output logic [COORD_W-1:0]            draw_y1,
    output logic [DATA_W-2*COORD_W-1:0]   draw_color,
    output logic [7:0]                    alpha_val,
    output logic                          illegal_op
);

    localparam int CLR_W = DATA_W - 2*COORD_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(SCREEN_H - 1);

`ifdef DECODE_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WORD1,
        S_COMMIT,
        S_ALPHA_WAIT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LINE  = 3'b001,
        OP_RECT  = 3'b010,
        OP_FRECT = 3'b011,
        OP_ALPHA = 3'b100
    } opcode_t;

    typedef struct packed {
        logic [1:0]         op;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [CLR_W-1:0]   color;
    } shape_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CLR_W-1:0]   color_q, color_d;
    logic [7:0]         alpha_val_q, alpha_val_d;
    logic               inst_type_q, inst_type_d;
    logic               illegal_q, illegal_d;

    shape_t             buf_q [DEPTH];
    shape_t             buf_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [2:0]         op_w;
    logic               pop;
    logic               commit;
    logic               take;
    logic               full;
    shape_t             entry;

    function automatic logic [COORD_W-1:0] clip(input logic [COORD_W-1:0] v,
                                                input logic [COORD_W-1:0] lim);
        return (CLIP_EN && (v > lim)) ? lim : v;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign op_w = fifo_rdata[DATA_W-1 -: 3];
    assign full = (count_q == CNT_W'(DEPTH));

    // Decode FSM; word fields are captured as they are popped so the FIFO head can move on.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        color_d     = color_q;
        alpha_val_d = alpha_val_q;
        inst_type_d = inst_type_q;
        illegal_d   = illegal_q;
        pop         = 1'b0;
        commit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (decode_en && !fifo_empty && !full && !inst_type_q) begin
                    pop = 1'b1;
                    case (op_w)
                        OP_NOP: begin
                        end
                        OP_LINE, OP_RECT, OP_FRECT: begin
                            op_d    = op_w[1:0];
                            x0_d    = fifo_rdata[2*COORD_W-1:COORD_W];
                            y0_d    = fifo_rdata[COORD_W-1:0];
                            state_d = S_WORD1;
                        end
                        OP_ALPHA: begin
                            alpha_val_d = fifo_rdata[7:0];
                            inst_type_d = 1'b1;
                            state_d     = S_ALPHA_WAIT;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            S_WORD1: begin
                // Shape fetch is atomic: decode_en is not consulted for the second word.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    color_d = fifo_rdata[DATA_W-1:2*COORD_W];
                    x1_d    = fifo_rdata[2*COORD_W-1:COORD_W];
                    y1_d    = fifo_rdata[COORD_W-1:0];
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            S_ALPHA_WAIT: begin
                if (alpha_fin) begin
                    inst_type_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        entry.op    = op_q;
        entry.x0    = clip(x0_q, X_MAX);
        entry.y0    = clip(y0_q, Y_MAX);
        entry.x1    = clip(x1_q, X_MAX);
        entry.y1    = clip(y1_q, Y_MAX);
        entry.color = color_q;
    end

    // Shape buffer: simultaneous commit and consume keeps the count and advances both pointers.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        take     = draw_fin && (count_q != '0);

        if (commit) begin
            buf_d[wr_ptr_q] = entry;
            wr_ptr_d        = ptr_next(wr_ptr_q);
        end
        if (take) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end

        case ({commit, take})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            alpha_val_q <= '0;
            inst_type_q <= 1'b0;
            illegal_q   <= 1'b0;
            buf_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            alpha_val_q <= alpha_val_d;
            inst_type_q <= inst_type_d;
            illegal_q   <= illegal_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign fifo_pop    = pop;
    assign decode_fin  = commit;
    assign inst_type   = inst_type_q;
    assign decode_full = full;
    assign draw_valid  = (count_q != '0);
    assign draw_op     = buf_q[rd_ptr_q].op;
    assign draw_x0     = buf_q[rd_ptr_q].x0;
    assign draw_y0     = buf_q[rd_ptr_q].y0;
    assign draw_x1     = buf_q[rd_ptr_q].x1;
    assign draw_y1     = buf_q[rd_ptr_q].y1;
    assign draw_color  = buf_q[rd_ptr_q].color;
    assign alpha_val   = alpha_val_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: instruction-level reference model (FIFO queue,
// expected shape/alpha queues, buffer occupancy) plus directed and randomized scenarios.
module tb_instruction_decoder;

    localparam int DATA_W  = 32;
    localparam int COORD_W = 10;
    localparam int DEPTH   = 2;
    localparam int CLR_W   = DATA_W - 2*COORD_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               decode_en;
    logic [DATA_W-1:0]  fifo_rdata;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               draw_fin;
    logic               alpha_fin;
    logic               decode_fin;
    logic               inst_type;
    logic               decode_full;
    logic               draw_valid;
    logic [1:0]         draw_op;
    logic [COORD_W-1:0] draw_x0, draw_y0, draw_x1, draw_y1;
    logic [CLR_W-1:0]   draw_color;
    logic [7:0]         alpha_val;
    logic               illegal_op;

    always #5 clk = ~clk;

    instruction_decoder #(
        .DATA_W  (DATA_W),
        .COORD_W (COORD_W),
        .DEPTH   (DEPTH),
        .SCREEN_W(640),
        .SCREEN_H(480)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .decode_en  (decode_en),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .draw_fin   (draw_fin),
        .alpha_fin  (alpha_fin),
        .decode_fin (decode_fin),
        .inst_type  (inst_type),
        .decode_full(decode_full),
        .draw_valid (draw_valid),
        .draw_op    (draw_op),
        .draw_x0    (draw_x0),
        .draw_y0    (draw_y0),
        .draw_x1    (draw_x1),
        .draw_y1    (draw_y1),
        .draw_color (draw_color),
        .alpha_val  (alpha_val),
        .illegal_op (illegal_op)
    );

    typedef struct {
        logic [1:0]         op;
        logic [COORD_W-1:0] x0, y0, x1, y1;
        logic [CLR_W-1:0]   color;
    } shape_s;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] fifo_q[$];
    shape_s            exp_shape[$];
    int                exp_alpha[$];
    int  vis         = -1;
    int  occ         = 0;
    int  alpha_cnt   = 0;
    int  alpha_delay = 2;
    int  draw_prob   = 0;
    int  fin_seen    = 0;
    bit  prev_inst   = 0;
    bit  expect_clear = 0;
    bit  de_drv      = 0;
    bit  any_illegal = 0;
    bit  s_pop, s_fin, s_valid, s_full, s_inst;

    function automatic int clip_x(input int v);
`ifdef DECODE_CLIP_EN
        return (v > 639) ? 639 : v;
`else
        return v;
`endif
    endfunction

    function automatic int clip_y(input int v);
`ifdef DECODE_CLIP_EN
        return (v > 479) ? 479 : v;
`else
        return v;
`endif
    endfunction

    task automatic push_shape(input int op, input int x0, input int y0,
                              input int x1, input int y1, input int color);
        shape_s e;
        fifo_q.push_back({3'(op), 9'($urandom), 10'(x0), 10'(y0)});
        fifo_q.push_back({12'(color), 10'(x1), 10'(y1)});
        e.op    = 2'(op);
        e.x0    = 10'(clip_x(x0));
        e.y0    = 10'(clip_y(y0));
        e.x1    = 10'(clip_x(x1));
        e.y1    = 10'(clip_y(y1));
        e.color = 12'(color);
        exp_shape.push_back(e);
    endtask

    task automatic push_alpha(input int a);
        logic [DATA_W-1:0] w;
        w = {3'b100, 21'($urandom), 8'(a)};
        fifo_q.push_back(w);
        exp_alpha.push_back(a & 255);
    endtask

    task automatic push_misc(input int op);
        fifo_q.push_back({3'(op), 29'($urandom)});
        if (op >= 5) any_illegal = 1;
    endtask

    function automatic bit model_idle();
        return fifo_q.size() == 0 && exp_shape.size() == 0 && exp_alpha.size() == 0 &&
               occ == 0 && !prev_inst && !expect_clear;
    endfunction

    // One clock cycle: present FIFO head, sample outputs, respond as draw/alpha units, update model.
    task automatic tick();
        bit df, af;
        shape_s e;
        @(negedge clk);
        fifo_empty = (fifo_q.size() == 0) || (vis == 0);
        fifo_rdata = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        decode_en  = de_drv;
        draw_fin   = 1'b0;
        alpha_fin  = 1'b0;
        #1;
        s_pop = fifo_pop; s_fin = decode_fin; s_valid = draw_valid;
        s_full = decode_full; s_inst = inst_type;
        df = 0; af = 0;

        checks++;
        if (s_pop && fifo_empty) begin
            failures++; $display("FAIL pop_when_empty: fifo_pop=%0b while fifo_empty=1", s_pop);
        end
        checks++;
        if (s_valid !== (occ > 0)) begin
            failures++; $display("FAIL draw_valid: got %0b exp %0b", s_valid, occ > 0);
        end
        checks++;
        if (s_full !== (occ == DEPTH)) begin
            failures++; $display("FAIL decode_full: got %0b exp %0b", s_full, occ == DEPTH);
        end
        if (expect_clear) begin
            checks++;
            if (s_inst !== 1'b0) begin
                failures++; $display("FAIL inst_type_clear: got %0b exp 0", s_inst);
            end
            expect_clear = 0;
        end
        if (s_inst) begin
            checks++;
            if (s_pop) begin
                failures++; $display("FAIL pop_during_alpha: fifo_pop=1 exp 0");
            end
        end
        if (s_inst && !prev_inst) begin
            checks++;
            if (exp_alpha.size() == 0) begin
                failures++; $display("FAIL alpha_unexpected: inst_type=1 exp 0");
            end else begin
                int a;
                a = exp_alpha.pop_front();
                if (alpha_val !== 8'(a)) begin
                    failures++; $display("FAIL alpha_val: got %h exp %h", alpha_val, 8'(a));
                end
            end
            alpha_cnt = alpha_delay;
        end
        if (s_inst) begin
            if (alpha_cnt == 0) begin
                af = 1; expect_clear = 1;
            end else alpha_cnt--;
        end else if ($urandom_range(0, 9) == 0) af = 1;

        if (s_valid && ($urandom_range(1, 100) <= draw_prob)) df = 1;
        else if (!s_valid && draw_prob > 0 && $urandom_range(0, 9) == 0) df = 1;
        if (df && s_valid) begin
            checks++;
            if (exp_shape.size() == 0) begin
                failures++; $display("FAIL draw_unexpected: draw_valid=1 exp 0");
            end else begin
                e = exp_shape.pop_front();
                if ({draw_op, draw_x0, draw_y0, draw_x1, draw_y1, draw_color} !==
                    {e.op, e.x0, e.y0, e.x1, e.y1, e.color}) begin
                    failures++;
                    $display("FAIL draw_head: got op=%0d x0=%0d y0=%0d x1=%0d y1=%0d c=%h exp op=%0d x0=%0d y0=%0d x1=%0d y1=%0d c=%h",
                             draw_op, draw_x0, draw_y0, draw_x1, draw_y1, draw_color,
                             e.op, e.x0, e.y0, e.x1, e.y1, e.color);
                end
            end
        end
        draw_fin  = df;
        alpha_fin = af;
        prev_inst = s_inst;
        if (s_fin) fin_seen++;
        occ = occ + (s_fin ? 1 : 0) - ((df && occ > 0) ? 1 : 0);
        if (s_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            if (vis > 0) vis--;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        de_drv = 1; draw_prob = 100; n = 0;
        while (!model_idle() && n < budget) begin
            tick(); n++;
        end
        checks++;
        if (!model_idle()) begin
            failures++;
            $display("FAIL drain_timeout: fifo=%0d shapes=%0d alphas=%0d occ=%0d exp all 0",
                     fifo_q.size(), exp_shape.size(), exp_alpha.size(), occ);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fifo_q.delete(); exp_shape.delete(); exp_alpha.delete();
        occ = 0; prev_inst = 0; expect_clear = 0; vis = -1; de_drv = 0;
        decode_en = 0; draw_fin = 0; alpha_fin = 0; fifo_empty = 1; fifo_rdata = '0;
        #1;
        checks++;
        if ({fifo_pop, decode_fin, inst_type, decode_full, draw_valid, illegal_op} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: pop=%0b fin=%0b inst=%0b full=%0b valid=%0b ill=%0b exp all 0",
                     fifo_pop, decode_fin, inst_type, decode_full, draw_valid, illegal_op);
        end
        checks++;
        if ({draw_op, draw_x0, draw_y0, draw_x1, draw_y1, draw_color} !== '0) begin
            failures++; $display("FAIL reset_draw: op=%0d x0=%0d color=%h exp 0", draw_op, draw_x0, draw_color);
        end
        checks++;
        if (alpha_val !== 8'h00) begin
            failures++; $display("FAIL reset_alpha: got %h exp 00", alpha_val);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_latency();
        de_drv = 1; draw_prob = 0;
        push_shape(1, 'h48, 'h0A, 'h123, 'h05, 'hABC);
        tick();
        checks++;
        if (s_pop !== 1'b1) begin failures++; $display("FAIL lat_pop_w0: got %0b exp 1", s_pop); end
        tick();
        checks++;
        if ({s_pop, s_fin} !== 2'b10) begin failures++; $display("FAIL lat_pop_w1: pop,fin=%b exp 10", {s_pop, s_fin}); end
        tick();
        checks++;
        if ({s_pop, s_fin, s_valid} !== 3'b010) begin failures++; $display("FAIL lat_fin: pop,fin,valid=%b exp 010", {s_pop, s_fin, s_valid}); end
        tick();
        checks++;
        if ({s_valid, draw_op, draw_color} !== {1'b1, 2'b01, 12'hABC}) begin
            failures++; $display("FAIL lat_draw: valid=%0b op=%0d color=%h exp 1 1 abc", s_valid, draw_op, draw_color);
        end
        drain(50);
    endtask

    task automatic test_full();
        de_drv = 1; draw_prob = 0;
        for (int i = 0; i < 3; i++)
            push_shape(2, $urandom_range(0, 639), $urandom_range(0, 479),
                       $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 4095));
        repeat (12) tick();
        checks++;
        if (s_full !== 1'b1) begin failures++; $display("FAIL full_flag: got %0b exp 1", s_full); end
        checks++;
        if (fifo_q.size() != 2) begin failures++; $display("FAIL full_no_pop: words left %0d exp 2", fifo_q.size()); end
        draw_prob = 100;
        tick();
        draw_prob = 0;
        repeat (8) tick();
        checks++;
        if ({s_full, fifo_q.size() == 0} !== 2'b11) begin
            failures++; $display("FAIL full_refill: full=%0b words left %0d exp 1 0", s_full, fifo_q.size());
        end
        drain(50);
    endtask

    task automatic test_alpha();
        de_drv = 1; draw_prob = 0; alpha_delay = 3;
        push_alpha('h80);
        push_shape(3, 10, 20, 30, 40, 'h123);
        tick();
        checks++;
        if (s_pop !== 1'b1) begin failures++; $display("FAIL alpha_pop: got %0b exp 1", s_pop); end
        tick();
        checks++;
        if ({s_inst, s_fin, alpha_val} !== {1'b1, 1'b0, 8'h80}) begin
            failures++; $display("FAIL alpha_pending: inst=%0b fin=%0b alpha=%h exp 1 0 80", s_inst, s_fin, alpha_val);
        end
        drain(60);
    endtask

    task automatic test_word1_stall();
        vis = 1; de_drv = 1; draw_prob = 0;
        push_shape(1, 100, 200, 300, 400, 'h5A5);
        tick();
        de_drv = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({s_pop, s_fin} !== 2'b00) begin failures++; $display("FAIL stall_w1: pop,fin=%b exp 00", {s_pop, s_fin}); end
        end
        vis = -1;
        tick();
        checks++;
        if (s_pop !== 1'b1) begin failures++; $display("FAIL stall_resume_pop: got %0b exp 1", s_pop); end
        tick();
        checks++;
        if (s_fin !== 1'b1) begin failures++; $display("FAIL stall_fin: got %0b exp 1", s_fin); end
        drain(50);
    endtask

    task automatic test_clip();
        push_shape(1, 1000, 700, 1000, 1023, 'hFFF);
        push_shape(2, 639, 479, 640, 480, 'h001);
        drain(60);
    endtask

    task automatic test_random();
        int k, n;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 9);
            if (k < 6)      push_shape($urandom_range(1, 3), $urandom_range(0, 1023), $urandom_range(0, 1023),
                                       $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 4095));
            else if (k < 8) push_alpha($urandom_range(0, 255));
            else if (k < 9) push_misc(0);
            else            push_misc($urandom_range(5, 7));
        end
        draw_prob = 50; n = 0;
        while (!model_idle() && n < 3000) begin
            de_drv = ($urandom_range(0, 3) != 0);
            alpha_delay = $urandom_range(0, 4);
            tick(); n++;
        end
        drain(500);
        checks++;
        if (illegal_op !== any_illegal) begin
            failures++; $display("FAIL rand_illegal: got %0b exp %0b", illegal_op, any_illegal);
        end
    endtask

    task automatic test_reset_mid();
        vis = 1; de_drv = 1; draw_prob = 100;
        fifo_q.push_back({3'b001, 9'd0, 10'd50, 10'd60});
        tick();
        do_reset();
        fifo_q.push_back({12'h0AB, 10'd70, 10'd80});
        de_drv = 1; draw_prob = 100; fin_seen = 0;
        repeat (6) tick();
        checks++;
        if (fin_seen != 0 || fifo_q.size() != 0) begin
            failures++; $display("FAIL reset_mid: decode_fin count %0d words left %0d exp 0 0", fin_seen, fifo_q.size());
        end
    endtask

    task automatic test_illegal();
        de_drv = 1; draw_prob = 0;
        checks++;
        if (illegal_op !== 1'b0) begin failures++; $display("FAIL illegal_pre: got %0b exp 0", illegal_op); end
        push_misc(7);
        tick();
        tick();
        checks++;
        if ({illegal_op, fifo_q.size() == 0} !== 2'b11) begin
            failures++; $display("FAIL illegal_set: ill=%0b words left %0d exp 1 0", illegal_op, fifo_q.size());
        end
        push_shape(2, 5, 6, 7, 8, 'h321);
        drain(50);
        checks++;
        if (illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_sticky: got %0b exp 1", illegal_op); end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; decode_en = 0; draw_fin = 0; alpha_fin = 0;
        fifo_empty = 1; fifo_rdata = '0;
        test_reset();
        test_latency();
        test_full();
        test_alpha();
        test_word1_stall();
        test_clip();
        test_random();
        test_reset_mid();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
